// File: rtl/silife_spi_tx.sv
// silife_spi_tx: buffered MAX7219 frame transmitter (SPI mode 0, MSB first).
// Frames carry CHAIN words under one CS-low window. SCK half-period is CLK_DIV clocks.
// Build option SILIFE_SPI_TX_FIFO_EN selects the word buffer:
//   defined:   FIFO_DEPTH-entry FIFO, o_ready = not full
//   undefined: single holding register, o_ready = register empty
module silife_spi_tx #(
    parameter int unsigned CHAIN      = 4,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_word,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_cs,
    output logic        o_sck,
    output logic        o_mosi,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned DIV_W  = $clog2(2 * CLK_DIV);
    localparam int unsigned WC_W   = (CHAIN > 1) ? $clog2(CHAIN) : 1;
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(CHAIN - 1);

    // Reject illegal configurations at elaboration
    if (CHAIN < 1 || CLK_DIV < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("silife_spi_tx: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_HOLD,
        S_GAP
    } state_t;

    logic              push;
    logic              pop;
    logic              buf_avail;
    logic [WORD_W-1:0] buf_head;

    assign push = i_valid & o_ready;

`ifdef SILIFE_SPI_TX_FIFO_EN
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;

    assign o_ready   = (count != CNT_W'(FIFO_DEPTH));
    assign buf_avail = (count != '0);
    assign buf_head  = mem[rd_ptr];

    // FIFO storage, written on accepted words
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
`else
    logic              hold_valid;
    logic [WORD_W-1:0] hold_data;

    assign o_ready   = ~hold_valid;
    assign buf_avail = hold_valid;
    assign buf_head  = hold_data;

    // Single pending-word register; push and pop never coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= i_word;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [3:0]        bit_cnt, bit_nxt;
    logic [WC_W-1:0]   word_cnt, word_nxt;
    logic [WORD_W-1:0] shreg, shreg_nxt;
    logic              cs_nxt, sck_nxt, mosi_nxt, busy_nxt, done_nxt;
    logic              load;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath and pin values
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        word_nxt  = word_cnt;
        shreg_nxt = shreg;
        cs_nxt    = o_cs;
        sck_nxt   = o_sck;
        mosi_nxt  = o_mosi;
        busy_nxt  = o_busy;
        done_nxt  = 1'b0;
        load      = 1'b0;

        case (state)
            S_IDLE: begin
                if (buf_avail) begin
                    load      = 1'b1;
                    cs_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_cnt != HALF_LAST) begin
                    div_nxt = div_cnt + DIV_W'(1);
                end else begin
                    div_nxt = '0;
                    if (!o_sck) begin
                        sck_nxt = 1'b1;
                    end else begin
                        sck_nxt = 1'b0;
                        if (bit_cnt != 4'd0) begin
                            bit_nxt  = bit_cnt - 4'd1;
                            mosi_nxt = shreg[bit_cnt - 4'd1];
                        end else if (word_cnt == WORD_LAST) begin
                            word_nxt  = '0;
                            state_nxt = S_HOLD;
                        end else begin
                            word_nxt = word_cnt + WC_W'(1);
                            if (buf_avail) begin
                                load = 1'b1;
                            end else begin
                                state_nxt = S_WAIT;
                            end
                        end
                    end
                end
            end
            S_WAIT: begin
                if (buf_avail) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_HOLD: begin
                if (div_cnt != HALF_LAST) begin
                    div_nxt = div_cnt + DIV_W'(1);
                end else begin
                    div_nxt   = '0;
                    cs_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (div_cnt != GAP_LAST) begin
                    div_nxt = div_cnt + DIV_W'(1);
                end else begin
                    div_nxt   = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Start a new word: low phase of bit 15 begins
        if (load) begin
            shreg_nxt = buf_head;
            mosi_nxt  = buf_head[WORD_W-1];
            bit_nxt   = 4'd15;
            div_nxt   = '0;
            sck_nxt   = 1'b0;
        end
        pop = load;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            shreg        <= '0;
            o_cs         <= 1'b1;
            o_sck        <= 1'b0;
            o_mosi       <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            div_cnt      <= div_nxt;
            bit_cnt      <= bit_nxt;
            word_cnt     <= word_nxt;
            shreg        <= shreg_nxt;
            o_cs         <= cs_nxt;
            o_sck        <= sck_nxt;
            o_mosi       <= mosi_nxt;
            o_busy       <= busy_nxt;
            o_frame_done <= done_nxt;
        end
    end

endmodule
